io_ctrl: RTL and testbench
==========================

# io_ctrl

Memory-mapped I/O controller on the CPU data-memory port, downstream of the memory stage. It decodes the 0xFFF0–0xFFFE window and returns read data alongside the data RAM. It synchronizes and debounces the push-keys and switches, captures sticky key-press events, and holds the HEX/LEDR/LEDG output registers. An optional free-running tick timer can be compiled in.

## Interface
Parameters:
- DBITS, 16, data/address width.
- DEBOUNCE, 50000, consecutive stable cycles required to accept a key change (≥2).
- TICK_DIV, 50000, CLK cycles per timer tick (≥2; used only with IO_TIMER_EN).

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RESET_N  in  1  asynchronous, active-low reset.
- ADDR  in  DBITS  data address from the memory stage. ADDR[0] is ignored.
- DIN  in  DBITS  store data.
- WE  in  1  store strobe. It is qualified internally by SEL.
- SEL  out  1  combinational; 1 when ADDR[15:4]==12'hFFF.
- DOUT  out  DBITS  combinational read data for ADDR.
- KEY  in  4  raw board keys; 0 means pressed.
- SW  in  10  raw board switches.
- HEX  out  16  seven-segment value, 4 nibbles.
- LEDR  out  10  red LEDs.
- LEDG  out  8  green LEDs.

## Operation
Address map (read / write):
- 0xFFF0 KEYS: reads {12'b0, kstable[3:0]}, where 1 means pressed. Writes are ignored.
- 0xFFF2 SW: reads {6'b0, swsync[9:0]}. Writes are ignored.
- 0xFFF4 KEDGE: reads {12'b0, kedge[3:0]}. A write is write-1-to-clear using DIN[3:0].
- 0xFFF6 TIMER: reads the count; a write loads DIN (IO_TIMER_EN only, otherwise unmapped).
- 0xFFF8 HEX: read/write, full 16 bits.
- 0xFFFA LEDR: read/write; only DIN[9:0] is stored; reads return zero-extended.
- 0xFFFC LEDG: read/write; only DIN[7:0] is stored; reads return zero-extended.
- Any other SEL address, including 0xFFFE: reads 16'hDEAD, writes are ignored.
- When SEL=0: DOUT=16'hDEAD and no write occurs.

Input synchronization:
- KEY and SW each pass through 2-flop synchronizers.
- ksync = ~KEY after synchronization, so 1 means pressed.

Debounce, one counter per key, states TRACK/COUNT:
- If ksync[i]==kstable[i], the counter resets to 0.
- Otherwise the counter increments. When the counter reaches DEBOUNCE-1, kstable[i] takes ksync[i] and the counter resets.
- A single mismatched glitch shorter than DEBOUNCE cycles never changes kstable.

Edge capture:
- kedge[i] sets on the edge where kstable[i] goes 0→1.
- Key release does not set kedge.
- If a W1C and a set hit the same bit in the same cycle, set wins.

Timer (IO_TIMER_EN):
- A prescaler counts 0..TICK_DIV-1. On wrap the timer increments by 1, wrapping 0xFFFF→0x0000.
- A write to TIMER loads DIN and clears the prescaler. The write wins over a coincident tick.

## Timing
- Reset (asynchronous, active-low) values:
  - HEX=0, LEDR=0, LEDG=0.
  - kstable=0, kedge=0.
  - key sync flops=0 (released), SW sync flops=0.
  - debounce counters=0, timer=0, prescaler=0.
- Reset asserted mid-debounce or mid-count aborts the operation with no partial update.
- Writes commit on the posedge where WE&SEL=1. The new value is visible on the outputs and on DOUT from the following cycle.
- Reads are combinational, with zero added latency, matching data-RAM read timing in the same stage.
- Key press latency: with KEY low continuously from edge k, kstable and kedge update at edge k+1+DEBOUNCE (2 sync stages plus the debounce count).
- Switch latency: 2 edges.

## Configuration
- IO_TIMER_EN defined: the prescaler and 16-bit timer are compiled in, and 0xFFF6 is mapped as described.
- IO_TIMER_EN undefined: no timer logic exists, and 0xFFF6 reads 16'hDEAD with writes ignored.

## Test plan
All scenarios use DEBOUNCE=4 and TICK_DIV=3.
- Reset: pulse RESET_N low mid-run → HEX=0, LEDR=0, LEDG=0; reads of FFF0 and FFF4 return 0.
- Writes: write 0xFFF8←0xBEEF, 0xFFFA←0xFFFF, 0xFFFC←0x1234 → HEX=BEEF, LEDR=0x3FF, LEDG=0x34, readbacks match. Write 0xFFFE←1 → no output change; read 0xFFFE=DEAD. ADDR=0x0100 → SEL=0.
- Debounce: hold KEY[2]=0 from edge k → FFF0 reads 0x0004 from edge k+5 onward, and FFF4 reads 0x0004. A 3-cycle KEY[1] glitch → FFF0 is unchanged and KEDGE stays unset.
- W1C: with KEDGE=0x5, write FFF4←0x1 → reads 0x4. Write 0x4 in the same cycle as a new KEY[2] set event → reads 0x4.
- Switches: SW=0x2A5 → FFF2 reads 0x02A5 two edges later.
- Timer (IO_TIMER_EN): the count reaches 2 after 6 cycles. Write 0xFFFF → the count is 0x0000 three cycles later. Without IO_TIMER_EN → FFF6 reads DEAD.

Source files
------------

// File: rtl/io_ctrl.sv
// io_ctrl: memory-mapped I/O window 0xFFF0-0xFFFE on the CPU data-memory port.
// Synchronizes/debounces push-keys, synchronizes switches, captures sticky
// key-press events and holds the HEX/LEDR/LEDG output registers.
// Optional macro IO_TIMER_EN compiles in a free-running tick timer at 0xFFF6.
//
// Ports:
//   CLK      system clock, all state updates on posedge
//   RESET_N  asynchronous active-low reset
//   ADDR     data address (ADDR[0] ignored)
//   DIN      store data
//   WE       store strobe, qualified by SEL
//   SEL      combinational window select (ADDR[15:4] == 12'hFFF)
//   DOUT     combinational read data
//   KEY      raw keys, 0 = pressed
//   SW       raw switches
//   HEX      seven-segment value (4 nibbles)
//   LEDR     red LEDs
//   LEDG     green LEDs
module io_ctrl #(
    parameter int unsigned DBITS    = 16,
    parameter int unsigned DEBOUNCE = 50000,
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [DBITS-1:0] ADDR,
    input  logic [DBITS-1:0] DIN,
    input  logic             WE,
    output logic             SEL,
    output logic [DBITS-1:0] DOUT,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [15:0]      HEX,
    output logic [9:0]       LEDR,
    output logic [7:0]       LEDG
);

    localparam int unsigned CW = $clog2(DEBOUNCE);

    // Register index within the window (word-addressed, ADDR[0] dropped)
    logic [2:0] reg_idx;
    logic       wr;
    logic       unused_addr0;

    assign reg_idx      = ADDR[3:1];
    assign SEL          = &ADDR[DBITS-1:4];
    assign wr           = WE & SEL;
    assign unused_addr0 = ADDR[0];

    // Two-flop synchronizers; key flops hold the inverted key so 1 = pressed
    logic [3:0] kmeta, ksync;
    logic [9:0] swmeta, swsync;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            kmeta  <= '0;
            ksync  <= '0;
            swmeta <= '0;
            swsync <= '0;
        end else begin
            kmeta  <= ~KEY;
            ksync  <= kmeta;
            swmeta <= SW;
            swsync <= swmeta;
        end
    end

    // Per-key debounce: counter runs while ksync disagrees with kstable
    logic [3:0]         kstable, kstable_nxt;
    logic [3:0][CW-1:0] dcnt, dcnt_nxt;
    logic [3:0]         kedge, kedge_nxt, w1c;

    always_comb begin
        kstable_nxt = kstable;
        dcnt_nxt    = '0;
        for (int i = 0; i < 4; i++) begin
            if (ksync[i] != kstable[i]) begin
                if (dcnt[i] == CW'(DEBOUNCE - 1)) begin
                    kstable_nxt[i] = ksync[i];
                end else begin
                    dcnt_nxt[i] = dcnt[i] + CW'(1);
                end
            end
        end
    end

    // Sticky press capture; a coincident set beats the write-1-to-clear
    always_comb begin
        w1c       = (wr && reg_idx == 3'd2) ? DIN[3:0] : 4'b0;
        kedge_nxt = (kedge & ~w1c) | (kstable_nxt & ~kstable);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            kstable <= '0;
            dcnt    <= '0;
            kedge   <= '0;
        end else begin
            kstable <= kstable_nxt;
            dcnt    <= dcnt_nxt;
            kedge   <= kedge_nxt;
        end
    end

    // Output registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            HEX  <= '0;
            LEDR <= '0;
            LEDG <= '0;
        end else if (wr) begin
            case (reg_idx)
                3'd4:    HEX  <= DIN[15:0];
                3'd5:    LEDR <= DIN[9:0];
                3'd6:    LEDG <= DIN[7:0];
                default: ;
            endcase
        end
    end

`ifdef IO_TIMER_EN
    localparam int unsigned PW = $clog2(TICK_DIV);

    // Prescaled tick timer; a load restarts the prescaler and beats a tick
    logic [PW-1:0] presc;
    logic [15:0]   timer;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            presc <= '0;
            timer <= '0;
        end else if (wr && reg_idx == 3'd3) begin
            presc <= '0;
            timer <= DIN[15:0];
        end else if (presc == PW'(TICK_DIV - 1)) begin
            presc <= '0;
            timer <= timer + 16'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end
`endif

    // Combinational read mux
    logic [15:0] rdata;

    always_comb begin
        rdata = 16'hDEAD;
        if (SEL) begin
            case (reg_idx)
                3'd0:    rdata = {12'b0, kstable};
                3'd1:    rdata = {6'b0, swsync};
                3'd2:    rdata = {12'b0, kedge};
`ifdef IO_TIMER_EN
                3'd3:    rdata = timer;
`endif
                3'd4:    rdata = HEX;
                3'd5:    rdata = {6'b0, LEDR};
                3'd6:    rdata = {8'b0, LEDG};
                default: rdata = 16'hDEAD;
            endcase
        end
    end

    assign DOUT = DBITS'(rdata);

endmodule

// File: tb/tb_io_ctrl.sv
// tb_io_ctrl: directed plus randomized bench for io_ctrl (DEBOUNCE=4, TICK_DIV=3)
// against a history-based behavioural model of the I/O window.
module tb_io_ctrl;

    localparam int unsigned DEB  = 4;
    localparam int unsigned TDIV = 3;

    logic        CLK;
    logic        RESET_N;
    logic [15:0] ADDR, DIN, DOUT;
    logic        WE, SEL;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [15:0] HEX;
    logic [9:0]  LEDR;
    logic [7:0]  LEDG;

    io_ctrl #(.DBITS(16), .DEBOUNCE(DEB), .TICK_DIV(TDIV)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .ADDR(ADDR), .DIN(DIN), .WE(WE),
        .SEL(SEL), .DOUT(DOUT), .KEY(KEY), .SW(SW),
        .HEX(HEX), .LEDR(LEDR), .LEDG(LEDG)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: raw pressed-samples per edge (index 0 = latest), switch samples,
    // registers, and the timer as base + elapsed_cycles / TDIV.
    logic [3:0]  m_khist [DEB+2];
    logic [9:0]  m_swhist [2];
    logic [3:0]  m_kst, m_kedge;
    logic [15:0] m_hex;
    logic [9:0]  m_ledr;
    logic [7:0]  m_ledg;
    logic [15:0] m_tbase;
    int          m_tcyc;

    task automatic model_reset();
        for (int j = 0; j < DEB + 2; j++) m_khist[j] = 4'b0;
        m_swhist[0] = 10'b0;
        m_swhist[1] = 10'b0;
        m_kst   = 4'b0;
        m_kedge = 4'b0;
        m_hex   = 16'b0;
        m_ledr  = 10'b0;
        m_ledg  = 8'b0;
        m_tbase = 16'b0;
        m_tcyc  = 0;
    endtask

    function automatic logic [15:0] m_read(input logic [15:0] a);
        logic [15:0] tv;
        tv = 16'(m_tbase + 16'(m_tcyc / int'(TDIV)));
        if (a[15:4] != 12'hFFF) return 16'hDEAD;
        case (a[3:1])
            3'd0: return {12'b0, m_kst};
            3'd1: return {6'b0, m_swhist[1]};
            3'd2: return {12'b0, m_kedge};
`ifdef IO_TIMER_EN
            3'd3: return tv;
`endif
            3'd4: return m_hex;
            3'd5: return {6'b0, m_ledr};
            3'd6: return {8'b0, m_ledg};
            default: return 16'hDEAD;
        endcase
    endfunction

    // Apply one clock edge's worth of the rules to the model
    task automatic model_edge();
        logic       wr;
        logic [3:0] old_st, new_st, w1c;
        logic       all_diff;
        wr = WE && (ADDR[15:4] == 12'hFFF);
        for (int j = DEB + 1; j > 0; j--) m_khist[j] = m_khist[j-1];
        m_khist[0] = ~KEY;
        old_st = m_kst;
        new_st = old_st;
        // Stable flips once the synchronized value (2 edges old) has differed for DEB edges
        for (int i = 0; i < 4; i++) begin
            all_diff = 1'b1;
            for (int j = 2; j < DEB + 2; j++)
                if (m_khist[j][i] == old_st[i]) all_diff = 1'b0;
            if (all_diff) new_st[i] = ~old_st[i];
        end
        w1c = (wr && ADDR[3:1] == 3'd2) ? DIN[3:0] : 4'b0;
        m_kedge = (m_kedge & ~w1c) | (new_st & ~old_st);
        m_kst = new_st;
        if (wr && ADDR[3:1] == 3'd4) m_hex  = DIN;
        if (wr && ADDR[3:1] == 3'd5) m_ledr = DIN[9:0];
        if (wr && ADDR[3:1] == 3'd6) m_ledg = DIN[7:0];
`ifdef IO_TIMER_EN
        if (wr && ADDR[3:1] == 3'd3) begin
            m_tbase = DIN;
            m_tcyc  = 0;
        end else begin
            m_tcyc++;
        end
`endif
        m_swhist[1] = m_swhist[0];
        m_swhist[0] = SW;
    endtask

    task automatic check_outputs();
        check_eq("sel",  32'(SEL),  32'(ADDR[15:4] == 12'hFFF));
        check_eq("dout", 32'(DOUT), 32'(m_read(ADDR)));
        check_eq("hex",  32'(HEX),  32'(m_hex));
        check_eq("ledr", 32'(LEDR), 32'(m_ledr));
        check_eq("ledg", 32'(LEDG), 32'(m_ledg));
    endtask

    task automatic step(input logic [15:0] a, input logic [15:0] d, input logic w);
        ADDR = a;
        DIN  = d;
        WE   = w;
        @(posedge CLK);
        model_edge();
        #1;
        check_outputs();
    endtask

    // Mid-cycle asynchronous reset pulse, released on the falling edge
    task automatic do_reset();
        WE = 1'b0;
        RESET_N = 1'b0;
        #2;
        model_reset();
        check_eq("rst_hex",  32'(HEX),  32'h0);
        check_eq("rst_ledr", 32'(LEDR), 32'h0);
        check_eq("rst_ledg", 32'(LEDG), 32'h0);
        ADDR = 16'hFFF0;
        #1 check_eq("rst_keys", 32'(DOUT), 32'h0);
        ADDR = 16'hFFF4;
        #1 check_eq("rst_kedge", 32'(DOUT), 32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    initial begin
        RESET_N = 1'b0;
        KEY  = 4'hF;
        SW   = 10'b0;
        ADDR = 16'h0;
        DIN  = 16'h0;
        WE   = 1'b0;
        model_reset();
        #12;
        check_eq("init_hex", 32'(HEX), 32'h0);
        ADDR = 16'hFFF0;
        #1 check_eq("init_keys", 32'(DOUT), 32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Timer from reset
        for (int s = 0; s < 6; s++) step(16'hFFF6, 16'h0, 1'b0);
`ifdef IO_TIMER_EN
        check_eq("tmr_six", 32'(DOUT), 32'h2);
`else
        check_eq("tmr_unmapped", 32'(DOUT), 32'hDEAD);
`endif
        step(16'hFFF6, 16'hFFFF, 1'b1);
        for (int s = 0; s < 3; s++) step(16'hFFF6, 16'h0, 1'b0);
`ifdef IO_TIMER_EN
        check_eq("tmr_wrap", 32'(DOUT), 32'h0);
`else
        check_eq("tmr_wr_ign", 32'(DOUT), 32'hDEAD);
`endif

        // Output register writes and readback
        step(16'hFFF8, 16'hBEEF, 1'b1);
        check_eq("hex_wr", 32'(DOUT), 32'hBEEF);
        step(16'hFFFA, 16'hFFFF, 1'b1);
        check_eq("ledr_wr", 32'(DOUT), 32'h3FF);
        step(16'hFFFC, 16'h1234, 1'b1);
        check_eq("ledg_wr", 32'(DOUT), 32'h34);
        step(16'hFFFE, 16'h0001, 1'b1);
        check_eq("fffe_read", 32'(DOUT), 32'hDEAD);
        check_eq("fffe_hex", 32'(HEX), 32'hBEEF);
        step(16'h0100, 16'h5555, 1'b1);
        check_eq("out_sel", 32'(SEL), 32'h0);
        check_eq("out_dout", 32'(DOUT), 32'hDEAD);

        // Debounce latency of KEY[2]
        KEY = 4'b1011;
        for (int s = 1; s <= 6; s++) begin
            step(16'hFFF0, 16'h0, 1'b0);
            if (s == 5) check_eq("deb_early", 32'(DOUT), 32'h0);
            if (s == 6) check_eq("deb_lat", 32'(DOUT), 32'h4);
        end
        step(16'hFFF4, 16'h0, 1'b0);
        check_eq("kedge_set", 32'(DOUT), 32'h4);

        // 3-cycle glitch on KEY[1]
        KEY = 4'b1001;
        for (int s = 0; s < 3; s++) step(16'hFFF0, 16'h0, 1'b0);
        KEY = 4'b1011;
        for (int s = 0; s < 6; s++) step(16'hFFF0, 16'h0, 1'b0);
        check_eq("glitch_keys", 32'(DOUT), 32'h4);
        step(16'hFFF4, 16'h0, 1'b0);
        check_eq("glitch_kedge", 32'(DOUT), 32'h4);

        // Write-1-to-clear and set-wins
        KEY = 4'b1010;
        for (int s = 0; s < 6; s++) step(16'hFFF4, 16'h0, 1'b0);
        check_eq("kedge_5", 32'(DOUT), 32'h5);
        step(16'hFFF4, 16'h0001, 1'b1);
        check_eq("w1c", 32'(DOUT), 32'h4);
        KEY = 4'b1110;
        for (int s = 0; s < 7; s++) step(16'hFFF0, 16'h0, 1'b0);
        check_eq("release_keys", 32'(DOUT), 32'h1);
        step(16'hFFF4, 16'h0, 1'b0);
        check_eq("release_kedge", 32'(DOUT), 32'h4);
        KEY = 4'b1010;
        for (int s = 0; s < 5; s++) step(16'hFFF4, 16'h0, 1'b0);
        step(16'hFFF4, 16'h0004, 1'b1);
        check_eq("set_wins", 32'(DOUT), 32'h4);
        step(16'hFFF0, 16'h0, 1'b0);
        check_eq("repress_keys", 32'(DOUT), 32'h5);

        // Switch latency
        SW = 10'h2A5;
        step(16'hFFF2, 16'h0, 1'b0);
        step(16'hFFF2, 16'h0, 1'b0);
        check_eq("sw_lat", 32'(DOUT), 32'h2A5);

        // Reset mid-run
        do_reset();
        step(16'hFFF8, 16'h0, 1'b0);

        // Randomized traffic
        for (int it = 0; it < 600; it++) begin
            logic [15:0] a;
            if (it == 300) do_reset();
            if ($urandom_range(0, 7) == 0) begin
                int kb;
                kb = int'($urandom_range(0, 3));
                KEY[kb] = ~KEY[kb];
            end
            if ($urandom_range(0, 3) == 0) SW = 10'($urandom);
            if ($urandom_range(0, 3) != 0) a = {12'hFFF, 4'($urandom_range(0, 15))};
            else a = 16'($urandom);
            step(a, 16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
